// File: rtl/sd_block_responder.sv
// rtl/sd_block_responder.sv - three-drive 512-byte block responder onto a 16-bit backing memory
//
// Serves whole-block read/write requests from three drives, one drive at a time,
// with round-robin arbitration. Each block is 256 16-bit words. The backing memory
// word address is {drive, lba, word}.
//
// Ports:
//   clk_sys, reset                     clock, async active-high reset
//   sd_lba0..2     in  32              block address per drive
//   sd_rd, sd_wr   in  3               level read/write request per drive
//   sd_ack         out 3               transfer in progress, one-hot per drive
//   sd_buff_addr   out 8               word index within the block
//   sd_buff_dout   out 16              read data, qualified by sd_buff_wr
//   sd_buff_wr     out 1               one-cycle read-data strobe
//   sd_buff_din0..2 in 16              write data, valid one cycle after sd_buff_addr
//   mem_req/mem_we out 1               memory request/write, held until mem_ack
//   mem_addr       out MEM_AW          {drive[1:0], lba[LBA_W-1:0], word[7:0]}
//   mem_wdata      out 16, mem_rdata in 16, mem_ack in 1
module sd_block_responder #(
  parameter int LBA_W  = 12,
  parameter int MEM_AW = 22
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba0,
  input  logic [31:0]       sd_lba1,
  input  logic [31:0]       sd_lba2,
  input  logic [2:0]        sd_rd,
  input  logic [2:0]        sd_wr,
  output logic [2:0]        sd_ack,
  output logic [7:0]        sd_buff_addr,
  output logic [15:0]       sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [15:0]       sd_buff_din0,
  input  logic [15:0]       sd_buff_din1,
  input  logic [15:0]       sd_buff_din2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARB     = 3'd1;
  localparam logic [2:0] RD_MEM  = 3'd2;
  localparam logic [2:0] RD_PUT  = 3'd3;
  localparam logic [2:0] WR_ADDR = 3'd4;
  localparam logic [2:0] WR_CAP  = 3'd5;
  localparam logic [2:0] WR_MEM  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;      // first drive considered at next arbitration
  logic [1:0]       drv_q, drv_d;
  logic [LBA_W-1:0] lba_q, lba_d;
  logic             oor_q, oor_d;      // latched lba beyond the mapped range
  logic [7:0]       word_q, word_d;
  logic [2:0]       ack_q, ack_d;
  logic [7:0]       addr_q, addr_d;
  logic [15:0]      dout_q, dout_d;
  logic             bwr_q, bwr_d;
  logic [15:0]      wdata_q, wdata_d;

  logic [2:0]  req;
  logic [1:0]  grant, idx;
  logic        grant_valid;
  logic [31:0] lba_sel;
  logic [15:0] din_sel;

  assign req = sd_rd | sd_wr;

  // Round-robin scan starting at ptr_q.
  always_comb begin
    grant       = ptr_q;
    grant_valid = 1'b0;
    idx         = ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  assign lba_sel = (grant == 2'd0) ? sd_lba0 : (grant == 2'd1) ? sd_lba1 : sd_lba2;
  assign din_sel = (drv_q == 2'd0) ? sd_buff_din0 : (drv_q == 2'd1) ? sd_buff_din1 : sd_buff_din2;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    drv_d   = drv_q;
    lba_d   = lba_q;
    oor_d   = oor_q;
    word_d  = word_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    bwr_d   = 1'b0;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        if (grant_valid) begin
          drv_d  = grant;
          lba_d  = lba_sel[LBA_W-1:0];
          oor_d  = (lba_sel >> LBA_W) != 32'd0;
          word_d = 8'd0;
          addr_d = 8'd0;
          ack_d  = 3'b001 << grant;
          ptr_d  = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
          // Read wins when both directions are requested.
          state_d = sd_rd[grant] ? RD_MEM : WR_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RD_MEM: begin
        // Out-of-range blocks read as zeros without touching memory.
        if (oor_q || mem_ack) begin
          dout_d  = oor_q ? 16'd0 : mem_rdata;
          addr_d  = word_q;
          bwr_d   = 1'b1;
          state_d = RD_PUT;
        end
      end
      RD_PUT: begin
        if (word_q == 8'hFF) begin
          ack_d   = 3'b000;
          state_d = DONE;
        end else begin
          word_d  = word_q + 8'd1;
          state_d = RD_MEM;
        end
      end
      WR_ADDR: state_d = WR_CAP;
      WR_CAP: begin
        wdata_d = din_sel;
        state_d = WR_MEM;
      end
      WR_MEM: begin
        if (oor_q || mem_ack) begin
          if (word_q == 8'hFF) begin
            ack_d   = 3'b000;
            state_d = DONE;
          end else begin
            word_d  = word_q + 8'd1;
            addr_d  = word_q + 8'd1;
            state_d = WR_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      drv_q   <= 2'd0;
      lba_q   <= '0;
      oor_q   <= 1'b0;
      word_q  <= 8'd0;
      ack_q   <= 3'b000;
      addr_q  <= 8'd0;
      dout_q  <= 16'd0;
      bwr_q   <= 1'b0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drv_q   <= drv_d;
      lba_q   <= lba_d;
      oor_q   <= oor_d;
      word_q  <= word_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      bwr_q   <= bwr_d;
      wdata_q <= wdata_d;
    end
  end

  // Memory outputs derive only from state and latched registers, so they hold
  // steady for any mem_ack stall.
  assign mem_req      = ((state_q == RD_MEM) || (state_q == WR_MEM)) && !oor_q;
  assign mem_we       = (state_q == WR_MEM) && !oor_q;
  assign mem_addr     = {drv_q, lba_q, word_q};
  assign mem_wdata    = wdata_q;
  assign sd_ack       = ack_q;
  assign sd_buff_addr = addr_q;
  assign sd_buff_dout = dout_q;
  assign sd_buff_wr   = bwr_q;

endmodule

// File: tb/tb_sd_block_responder.sv
// tb/tb_sd_block_responder.sv - directed self-checking bench for sd_block_responder
module tb_sd_block_responder;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [31:0] sd_lba0 = '0, sd_lba1 = '0, sd_lba2 = '0;
  logic [2:0]  sd_rd = '0, sd_wr = '0;
  logic [2:0]  sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din0, sd_buff_din1, sd_buff_din2;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;

  logic [7:0]  stb_addr[$];
  logic [15:0] stb_dout[$];
  logic [21:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [2:0]  ack_log[$];
  int mem_req_cycles = 0, mem_unstable = 0, bad_strobe = 0, ack_overlap = 0;
  logic [2:0] prev_ack = '0;

  sd_block_responder #(.LBA_W(12), .MEM_AW(22)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .sd_lba0(sd_lba0), .sd_lba1(sd_lba1), .sd_lba2(sd_lba2),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din0(sd_buff_din0), .sd_buff_din1(sd_buff_din1), .sd_buff_din2(sd_buff_din2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // Requester buffer: data appears one cycle after the address it belongs to.
  initial begin
    sd_buff_din0 = '0; sd_buff_din1 = '0; sd_buff_din2 = '0;
    forever begin
      @(posedge clk_sys); #1;
      sd_buff_din0 = {8'h00, sd_buff_addr};
      sd_buff_din1 = {8'h00, sd_buff_addr} ^ 16'h5555;
      sd_buff_din2 = ~{8'h00, sd_buff_addr};
    end
  end

  // Backing memory: every word holds its own address[15:0]; writes are logged.
  initial begin
    int cnt;
    logic [21:0] s_addr;
    logic        s_we;
    logic [15:0] s_wdata;
    cnt = 0; s_addr = '0; s_we = 1'b0; s_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk_sys);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
        end else if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
          mem_unstable++;
        end
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr[15:0];
          if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
          end
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Observation of strobes, acks and memory activity.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd_buff_wr) begin
        stb_addr.push_back(sd_buff_addr);
        stb_dout.push_back(sd_buff_dout);
        if (sd_ack == 3'b000) bad_strobe++;
      end
      if (mem_req) mem_req_cycles++;
      if ($countones(sd_ack) > 1) ack_overlap++;
      if (sd_ack != prev_ack && sd_ack != 3'b000) ack_log.push_back(sd_ack);
      prev_ack = sd_ack;
    end
  end

  task automatic clear_logs();
    stb_addr.delete(); stb_dout.delete();
    wr_addr.delete(); wr_data.delete(); ack_log.delete();
    mem_req_cycles = 0; mem_unstable = 0; bad_strobe = 0; ack_overlap = 0;
  endtask

  task automatic wait_ack(input bit want_busy, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if ((sd_ack != 3'b000) == want_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_xfer(input logic [2:0] rd, input logic [2:0] wr, output bit ok, output logic [2:0] ack_seen);
    bit ok1, ok2;
    @(negedge clk_sys);
    sd_rd = rd; sd_wr = wr;
    wait_ack(1'b1, 20, ok1);
    ack_seen = sd_ack;
    sd_rd = 3'b000; sd_wr = 3'b000;
    wait_ack(1'b0, 4000, ok2);
    ok = ok1 && ok2;
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++; if (sd_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b want=000", sd_ack); end
    checks++; if (sd_buff_wr !== 1'b0) begin errors++; $display("FAIL reset_buff_wr got=%b want=0", sd_buff_wr); end
    checks++; if (sd_buff_addr !== 8'h00) begin errors++; $display("FAIL reset_buff_addr got=%h want=00", sd_buff_addr); end
    checks++; if (sd_buff_dout !== 16'h0000) begin errors++; $display("FAIL reset_buff_dout got=%h want=0000", sd_buff_dout); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_read();
    bit ok; logic [2:0] a; int bad; logic [21:0] e;
    clear_logs(); ack_delay = 0; sd_lba0 = 32'd5;
    run_xfer(3'b001, 3'b000, ok, a);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_handshake got=%b want=1", ok); end
    checks++; if (a !== 3'b001) begin errors++; $display("FAIL read_ack got=%b want=001", a); end
    checks++; if (stb_addr.size() != 256) begin errors++; $display("FAIL read_strobes got=%0d want=256", stb_addr.size()); end
    bad = 0;
    for (int i = 0; i < stb_addr.size(); i++) begin
      e = {2'd0, 12'd5, 8'(i)};
      if (stb_addr[i] !== 8'(i) || stb_dout[i] !== e[15:0]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL read_data bad_words=%0d want=0", bad); end
    checks++; if (bad_strobe != 0) begin errors++; $display("FAIL read_strobe_outside_ack got=%0d want=0", bad_strobe); end
    repeat (20) @(negedge clk_sys);
    checks++; if (stb_addr.size() != 256 || sd_ack !== 3'b000) begin errors++; $display("FAIL read_no_second_pass strobes=%0d ack=%b want=256/000", stb_addr.size(), sd_ack); end
  endtask

  task automatic test_write();
    bit ok; logic [2:0] a; int bad; logic [21:0] e;
    clear_logs(); ack_delay = 0; sd_lba2 = 32'd3;
    run_xfer(3'b000, 3'b100, ok, a);
    checks++; if (ok !== 1'b1 || a !== 3'b100) begin errors++; $display("FAIL write_ack ok=%b ack=%b want=1/100", ok, a); end
    checks++; if (wr_addr.size() != 256) begin errors++; $display("FAIL write_count got=%0d want=256", wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      e = {2'd2, 12'd3, 8'(i)};
      if (wr_addr[i] !== e || wr_data[i] !== ~{8'h00, 8'(i)}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL write_data bad_words=%0d want=0", bad); end
    checks++; if (stb_addr.size() != 0) begin errors++; $display("FAIL write_strobes got=%0d want=0", stb_addr.size()); end
  endtask

  task automatic test_round_robin();
    bit ok; logic [15:0] d1, d2;
    reset = 1'b1; clear_logs(); ack_delay = 0;
    sd_lba0 = 32'd1; sd_lba1 = 32'd2; sd_lba2 = 32'd3; sd_rd = 3'b111;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (ack_log.size() >= 3) begin ok = 1'b1; break; end
    end
    sd_rd = 3'b000;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_three_grants got=%0d grants want=3", ack_log.size()); end
    wait_ack(1'b0, 4000, ok);
    repeat (5) @(negedge clk_sys);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_final_done got=%b want=1", ok); end
    checks++; if (ack_log.size() != 3 || ack_log[0] !== 3'b001 || ack_log[1] !== 3'b010 || ack_log[2] !== 3'b100)
      begin errors++; $display("FAIL rr_order n=%0d got=%p want=001,010,100", ack_log.size(), ack_log); end
    checks++; if (ack_overlap != 0) begin errors++; $display("FAIL rr_overlap got=%0d want=0", ack_overlap); end
    d1 = (stb_dout.size() > 256) ? stb_dout[256] : 16'hxxxx;
    d2 = (stb_dout.size() > 512) ? stb_dout[512] : 16'hxxxx;
    checks++; if (stb_dout.size() != 768 || d1 !== 16'h0200 || d2 !== 16'h0300)
      begin errors++; $display("FAIL rr_data n=%0d d1=%h d2=%h want=768/0200/0300", stb_dout.size(), d1, d2); end
  endtask

  task automatic test_out_of_range();
    bit ok; logic [2:0] a; int bad;
    clear_logs(); ack_delay = 0; sd_lba1 = 32'h0000_1000;
    run_xfer(3'b010, 3'b000, ok, a);
    checks++; if (ok !== 1'b1 || a !== 3'b010) begin errors++; $display("FAIL oor_ack ok=%b ack=%b want=1/010", ok, a); end
    checks++; if (stb_addr.size() != 256) begin errors++; $display("FAIL oor_strobes got=%0d want=256", stb_addr.size()); end
    bad = 0;
    for (int i = 0; i < stb_addr.size(); i++)
      if (stb_addr[i] !== 8'(i) || stb_dout[i] !== 16'h0000) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL oor_zero_data bad_words=%0d want=0", bad); end
    checks++; if (mem_req_cycles != 0) begin errors++; $display("FAIL oor_mem_req got=%0d want=0", mem_req_cycles); end
  endtask

  task automatic test_stall();
    bit ok; logic [2:0] a; int bad; logic [21:0] e;
    clear_logs(); ack_delay = 7; sd_lba0 = 32'd7;
    run_xfer(3'b001, 3'b000, ok, a);
    checks++; if (ok !== 1'b1 || stb_addr.size() != 256) begin errors++; $display("FAIL stall_read ok=%b strobes=%0d want=1/256", ok, stb_addr.size()); end
    bad = 0;
    for (int i = 0; i < stb_addr.size(); i++) begin
      e = {2'd0, 12'd7, 8'(i)};
      if (stb_addr[i] !== 8'(i) || stb_dout[i] !== e[15:0]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_read_data bad_words=%0d want=0", bad); end
    checks++; if (mem_unstable != 0) begin errors++; $display("FAIL stall_read_stable changes=%0d want=0", mem_unstable); end
    clear_logs(); sd_lba1 = 32'd9;
    run_xfer(3'b000, 3'b010, ok, a);
    checks++; if (ok !== 1'b1 || wr_addr.size() != 256) begin errors++; $display("FAIL stall_write ok=%b writes=%0d want=1/256", ok, wr_addr.size()); end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      e = {2'd1, 12'd9, 8'(i)};
      if (wr_addr[i] !== e || wr_data[i] !== ({8'h00, 8'(i)} ^ 16'h5555)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_write_data bad_words=%0d want=0", bad); end
    checks++; if (mem_unstable != 0 || stb_addr.size() != 0) begin errors++; $display("FAIL stall_write_stable changes=%0d strobes=%0d want=0/0", mem_unstable, stb_addr.size()); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid();
    bit ok; logic [2:0] a;
    clear_logs(); ack_delay = 0; sd_lba0 = 32'd2;
    @(negedge clk_sys); sd_rd = 3'b001;
    wait_ack(1'b1, 20, ok);
    sd_rd = 3'b000;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_sys);
      if (stb_addr.size() >= 100) break;
    end
    checks++; if (stb_addr.size() != 100 || sd_ack !== 3'b001) begin errors++; $display("FAIL mid_progress strobes=%0d ack=%b want=100/001", stb_addr.size(), sd_ack); end
    #2 reset = 1'b1;
    #1;
    checks++; if (sd_ack !== 3'b000 || sd_buff_wr !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0)
      begin errors++; $display("FAIL mid_reset_ctrl ack=%b wr=%b req=%b we=%b want=0", sd_ack, sd_buff_wr, mem_req, mem_we); end
    checks++; if (sd_buff_addr !== 8'h00 || sd_buff_dout !== 16'h0000)
      begin errors++; $display("FAIL mid_reset_buff addr=%h dout=%h want=00/0000", sd_buff_addr, sd_buff_dout); end
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    clear_logs();
    repeat (50) @(negedge clk_sys);
    checks++; if (stb_addr.size() != 0 || mem_req_cycles != 0 || sd_ack !== 3'b000)
      begin errors++; $display("FAIL mid_no_resume strobes=%0d mem_req=%0d ack=%b want=0/0/000", stb_addr.size(), mem_req_cycles, sd_ack); end
    run_xfer(3'b001, 3'b000, ok, a);
    checks++; if (ok !== 1'b1 || stb_addr.size() != 256 || stb_dout[0] !== 16'h0200)
      begin errors++; $display("FAIL mid_new_xfer ok=%b strobes=%0d want=1/256", ok, stb_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_out_of_range();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
